tetris_game_ctrl: RTL and testbench

- Parametrised next-generation Tetris game sequencer. Adds gravity timing, lock delay, a line-clear animation phase, level/line bookkeeping and key edge detection to the base start/spawn/play/check/game-over flow.
- Sits between the USB keyboard keycode path and the board/piece datapath.
- Issues one-cycle strobes (spawn, gravity, lock, scan) and exports state, level and line count to the renderer.

---
 rtl/tetris_pkg.sv | 27 ++
 rtl/tetris_level_tracker.sv | 44 ++++
 rtl/tetris_game_ctrl.sv | 157 +++++++++++++++
 tb/tb_tetris_game_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared state encoding, keycodes and gravity-period helper for the Tetris sequencer.
package tetris_pkg;

  typedef enum logic [3:0] {
    ST_START = 4'd0,
    ST_SPAWN = 4'd1,
    ST_PLAY  = 4'd2,
    ST_LOCK  = 4'd3,
    ST_CHECK = 4'd4,
    ST_CLEAR = 4'd5,
    ST_PAUSE = 4'd6,
    ST_OVER  = 4'd7
  } tetris_state_e;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_P     = 8'h13;

  // Drop period for a level: shrinks linearly, never below floor_p.
  function automatic logic [31:0] grav_period(input logic [3:0] lvl, input int unsigned base,
                                              input int unsigned step, input int unsigned floor_p);
    longint p;
    p = longint'(base) - longint'(lvl) * longint'(step);
    return (p < longint'(floor_p)) ? floor_p : 32'(p);
  endfunction

endpackage

// File: rtl/tetris_level_tracker.sv
// Cumulative line count and level progression, updated once per board scan.
module tetris_level_tracker
  import tetris_pkg::*;
#(
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        clear,
  input  logic        scan_valid,
  input  logic [2:0]  lines_cleared,
  output logic [3:0]  level,
  output logic [15:0] lines_total
);

  // Lines gathered toward the next level; the lines still needed is LINES_PER_LEVEL minus this.
  logic [31:0] lines_acc;
  logic [31:0] acc_sum;
  logic [31:0] acc_over;
  logic [16:0] total_sum;

  assign acc_sum   = lines_acc + 32'(lines_cleared);
  assign acc_over  = acc_sum - LINES_PER_LEVEL;
  assign total_sum = {1'b0, lines_total} + 17'(lines_cleared);

  always_ff @(posedge Clk) begin
    if (!Reset_n || clear) begin
      level       <= '0;
      lines_total <= '0;
      lines_acc   <= '0;
    end else if (scan_valid) begin
      lines_total <= total_sum[16] ? '1 : total_sum[15:0];
      if (acc_sum >= LINES_PER_LEVEL) begin
        if (level < 4'(MAX_LEVEL)) level <= level + 4'd1;
        // Only one level-up per scan; leave at least one line still needed.
        lines_acc <= (acc_over >= LINES_PER_LEVEL) ? LINES_PER_LEVEL - 32'd1 : acc_over;
      end else begin
        lines_acc <= acc_sum;
      end
    end
  end

endmodule

// File: rtl/tetris_game_ctrl.sv
// Tetris game sequencer: gravity, lock delay, line-clear phase and key edge detection.
// Optional pause support is built when TETRIS_PAUSE_EN is defined.
module tetris_game_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned GRAV_BASE       = 50_000_000,
  parameter int unsigned GRAV_STEP       = 3_000_000,
  parameter int unsigned GRAV_MIN        = 5_000_000,
  parameter int unsigned LOCK_CYCLES     = 25_000_000,
  parameter int unsigned LOCK_RESETS     = 15,
  parameter int unsigned CLEAR_CYCLES    = 12_500_000,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 15,
  parameter logic [7:0]  KEY_START       = KEY_SPACE,
  parameter logic [7:0]  KEY_RESTART     = KEY_ENTER,
  parameter logic [7:0]  KEY_PAUSE       = KEY_P
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode,
  input  logic        spawn_possible,
  input  logic        piece_grounded,
  input  logic        piece_moved,
  input  logic        line_scan_done,
  input  logic [2:0]  lines_cleared,
  output logic [3:0]  state_out,
  output logic        spawn_req,
  output logic        gravity_tick,
  output logic        lock_req,
  output logic        scan_start,
  output logic        clear_active,
  output logic [3:0]  level,
  output logic [15:0] lines_total
);

  tetris_state_e state;
  logic [7:0]  prev_key;
  logic [31:0] grav_cnt, lock_cnt, clr_cnt, resets_used, period;
  logic        check_seen, start_press, restart_press, pause_go;
  logic        grav_hit, lock_hit, reset_avail, scan_update, track_clear;

  assign start_press   = (keycode == KEY_START) && (prev_key != KEY_START);
  assign restart_press = (keycode == KEY_RESTART) && (prev_key != KEY_RESTART);

`ifdef TETRIS_PAUSE_EN
  tetris_state_e ret_state;
  assign pause_go = (keycode == KEY_PAUSE) && (prev_key != KEY_PAUSE);
`else
  logic pause_key_unused;
  assign pause_key_unused = (keycode == KEY_PAUSE);
  assign pause_go = 1'b0;
`endif

  assign period      = grav_period(level, GRAV_BASE, GRAV_STEP, GRAV_MIN);
  assign grav_hit    = grav_cnt >= period - 32'd1;
  assign lock_hit    = lock_cnt == LOCK_CYCLES - 32'd1;
  assign reset_avail = piece_moved && (resets_used < LOCK_RESETS);

  assign state_out    = state;
  assign spawn_req    = (state == ST_SPAWN);
  assign gravity_tick = (state == ST_PLAY) && grav_hit;
  assign lock_req     = (state == ST_LOCK) && piece_grounded && !reset_avail && lock_hit;
  assign scan_start   = (state == ST_CHECK) && !check_seen;
  assign clear_active = (state == ST_CLEAR);
  assign scan_update  = (state == ST_CHECK) && line_scan_done && (lines_cleared != 3'd0);
  assign track_clear  = (state == ST_START) && start_press;

  tetris_level_tracker #(
    .LINES_PER_LEVEL(LINES_PER_LEVEL),
    .MAX_LEVEL      (MAX_LEVEL)
  ) u_level (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .clear        (track_clear),
    .scan_valid   (scan_update),
    .lines_cleared(lines_cleared),
    .level        (level),
    .lines_total  (lines_total)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= ST_START;
      prev_key    <= '0;
      grav_cnt    <= '0;
      lock_cnt    <= '0;
      resets_used <= '0;
      clr_cnt     <= '0;
      check_seen  <= 1'b0;
`ifdef TETRIS_PAUSE_EN
      ret_state   <= ST_START;
`endif
    end else begin
      prev_key   <= keycode;
      check_seen <= (state == ST_CHECK);
      case (state)
        ST_START: if (start_press) state <= ST_SPAWN;
        ST_SPAWN: begin
          if (spawn_possible) begin
            state       <= ST_PLAY;
            grav_cnt    <= '0;
            resets_used <= '0;
          end else begin
            state <= ST_OVER;
          end
        end
        ST_PLAY: begin
          // A pause press only takes effect on a cycle without a gravity tick or grounding.
          if (grav_hit) grav_cnt <= '0;
          else if (piece_grounded || !pause_go) grav_cnt <= grav_cnt + 32'd1;
          if (piece_grounded) begin
            state    <= ST_LOCK;
            lock_cnt <= '0;
          end else if (pause_go && !grav_hit) begin
            state <= ST_PAUSE;
`ifdef TETRIS_PAUSE_EN
            ret_state <= ST_PLAY;
`endif
          end
        end
        ST_LOCK: begin
          if (!piece_grounded) begin
            state <= ST_PLAY;
          end else if (reset_avail) begin
            lock_cnt    <= '0;
            resets_used <= resets_used + 32'd1;
          end else if (lock_hit) begin
            state <= ST_CHECK;
          end else if (pause_go) begin
            state <= ST_PAUSE;
`ifdef TETRIS_PAUSE_EN
            ret_state <= ST_LOCK;
`endif
          end else begin
            lock_cnt <= lock_cnt + 32'd1;
          end
        end
        ST_CHECK: begin
          if (line_scan_done) begin
            state   <= (lines_cleared != 3'd0) ? ST_CLEAR : ST_SPAWN;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == CLEAR_CYCLES - 32'd1) state <= ST_SPAWN;
          else clr_cnt <= clr_cnt + 32'd1;
        end
`ifdef TETRIS_PAUSE_EN
        ST_PAUSE: if (pause_go) state <= ret_state;
`endif
        ST_OVER: if (restart_press) state <= ST_START;
        default: state <= ST_START;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Self-checking bench for tetris_game_ctrl: directed scenarios plus randomized play against a reference model.
module tb_tetris_game_ctrl;

  localparam int GBASE = 10, GSTEP = 2, GMIN = 4, LC = 8, LR = 2, CC = 3, LPL = 10, MAXL = 6;

  logic        Clk = 1'b0;
  logic        Reset_n, spawn_possible, piece_grounded, piece_moved, line_scan_done;
  logic [7:0]  keycode;
  logic [2:0]  lines_cleared;
  logic [3:0]  state_out, level;
  logic        spawn_req, gravity_tick, lock_req, scan_start, clear_active;
  logic [15:0] lines_total;

  int checks = 0;
  int passes = 0;

  always #5 Clk = ~Clk;

  tetris_game_ctrl #(
    .GRAV_BASE(GBASE), .GRAV_STEP(GSTEP), .GRAV_MIN(GMIN), .LOCK_CYCLES(LC), .LOCK_RESETS(LR),
    .CLEAR_CYCLES(CC), .LINES_PER_LEVEL(LPL), .MAX_LEVEL(MAXL),
    .KEY_START(8'h2C), .KEY_RESTART(8'h28), .KEY_PAUSE(8'h13)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .spawn_possible(spawn_possible),
    .piece_grounded(piece_grounded), .piece_moved(piece_moved), .line_scan_done(line_scan_done),
    .lines_cleared(lines_cleared), .state_out(state_out), .spawn_req(spawn_req),
    .gravity_tick(gravity_tick), .lock_req(lock_req), .scan_start(scan_start),
    .clear_active(clear_active), .level(level), .lines_total(lines_total)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_state(input string name, input int s, input int budget);
    for (int i = 0; i < budget && state_out !== 4'(s); i++) step();
    chk(name, state_out, s);
  endtask

  task automatic tick_gap(input string name, input int expgap);
    int t1, t2;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      #1;
      if (gravity_tick) begin
        if (t1 < 0) t1 = i; else t2 = i;
      end
      step();
    end
    chk(name, t2 - t1, expgap);
  endtask

  task automatic scan_round(input int n);
    wait_state("reach_check", 4, 40);
    line_scan_done = 1'b1; lines_cleared = 3'(n);
    step();
    line_scan_done = 1'b0;
  endtask

  // Reference model: game rules evaluated per cycle, lines-to-next kept as a countdown.
  int m_st, m_prev, m_grav, m_lck, m_rsv, m_clr, m_chk, m_lvl, m_tot, m_tonext, m_ret, m_per;
  bit m_tick, m_lkres, sp, rp, pp;
  logic [28:0] exp_vec;

  initial begin : model
    m_st = 0; m_prev = 0; m_grav = 0; m_lck = 0; m_rsv = 0; m_clr = 0; m_chk = 0;
    m_lvl = 0; m_tot = 0; m_tonext = LPL; m_ret = 0;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      m_per = GBASE - m_lvl * GSTEP;
      if (m_per < GMIN) m_per = GMIN;
      m_tick  = (m_st == 2) && (m_grav == m_per - 1);
      m_lkres = piece_moved && (m_rsv < LR);
      exp_vec = {4'(m_st), m_st == 1, m_tick,
                 (m_st == 3) && piece_grounded && !m_lkres && (m_lck == LC - 1),
                 (m_st == 4) && (m_chk == 0), m_st == 5, 4'(m_lvl), 16'(m_tot)};
      chk("cycle_outputs", {state_out, spawn_req, gravity_tick, lock_req, scan_start, clear_active,
                            level, lines_total}, exp_vec);
      if (!Reset_n) begin
        m_st = 0; m_prev = 0; m_grav = 0; m_lck = 0; m_rsv = 0; m_clr = 0; m_chk = 0;
        m_lvl = 0; m_tot = 0; m_tonext = LPL; m_ret = 0;
      end else begin
        sp = (keycode == 8'h2C) && (m_prev != 8'h2C);
        rp = (keycode == 8'h28) && (m_prev != 8'h28);
`ifdef TETRIS_PAUSE_EN
        pp = (keycode == 8'h13) && (m_prev != 8'h13);
`else
        pp = 1'b0;
`endif
        m_chk = (m_st == 4) ? m_chk + 1 : 0;
        case (m_st)
          0: if (sp) begin m_st = 1; m_lvl = 0; m_tot = 0; m_tonext = LPL; end
          1: if (spawn_possible) begin m_st = 2; m_grav = 0; m_rsv = 0; end else m_st = 7;
          2: begin
            if (piece_grounded) begin m_grav = m_tick ? 0 : m_grav + 1; m_st = 3; m_lck = 0; end
            else if (m_tick) m_grav = 0;
            else if (pp) begin m_ret = 2; m_st = 6; end
            else m_grav++;
          end
          3: begin
            if (!piece_grounded) m_st = 2;
            else if (m_lkres) begin m_lck = 0; m_rsv++; end
            else if (m_lck == LC - 1) m_st = 4;
            else if (pp) begin m_ret = 3; m_st = 6; end
            else m_lck++;
          end
          4: if (line_scan_done) begin
            if (lines_cleared > 0) begin
              m_st = 5; m_clr = 0;
              m_tot = m_tot + int'(lines_cleared);
              if (m_tot > 65535) m_tot = 65535;
              m_tonext = m_tonext - int'(lines_cleared);
              if (m_tonext <= 0) begin
                if (m_lvl < MAXL) m_lvl++;
                m_tonext = m_tonext + LPL;
                if (m_tonext <= 0) m_tonext = 1;
              end
            end else m_st = 1;
          end
          5: if (m_clr == CC - 1) m_st = 1; else m_clr++;
          6: if (pp) m_st = m_ret;
          7: if (rp) m_st = 0;
          default: m_st = 0;
        endcase
        m_prev = int'(keycode);
      end
    end
  end

  initial begin : stimulus
    logic [3:0] seq [5];
    int n_spawn, lockk, cnt;
    Reset_n = 1'b0; keycode = '0; spawn_possible = 1'b1; piece_grounded = 1'b0;
    piece_moved = 1'b0; line_scan_done = 1'b0; lines_cleared = '0;
    step(); step(); #1;
    chk("reset_state", state_out, 0);
    chk("reset_level", level, 0);
    chk("reset_lines", lines_total, 0);
    chk("reset_pulses", {spawn_req, gravity_tick, lock_req, scan_start, clear_active}, 0);

    // Start key held for 5 cycles: exactly one spawn.
    Reset_n = 1'b1; keycode = 8'h2C; n_spawn = 0;
    for (int i = 0; i < 5; i++) begin
      #1; seq[i] = state_out; n_spawn += int'(spawn_req);
      step();
    end
    keycode = '0;
    chk("start_seq", {seq[0], seq[1], seq[2], seq[3], seq[4]}, 20'h01222);
    chk("spawn_once", n_spawn, 1);

    tick_gap("gap_level0", 10);

    // Lock delay with two permitted restarts and one ignored.
    piece_grounded = 1'b1; step(); #1;
    chk("enter_lock", state_out, 3);
    for (int r = 0; r < 2; r++) begin
      repeat (5) step();
      piece_moved = 1'b1; step(); piece_moved = 1'b0;
    end
    lockk = -1;
    for (int k = 1; k < 20 && lockk < 0; k++) begin
      piece_moved = (k == 6); #1;
      if (lock_req) lockk = k;
      step();
    end
    piece_moved = 1'b0;
    chk("lock_after_reset", lockk, 8);
    #1;
    chk("check_entry", state_out, 4);
    chk("scan_start_first", scan_start, 1);

    // Three 4-line scans: 0 -> 4 -> 8 -> 12, level 1 on the last.
    scan_round(4);
    scan_round(4);
    wait_state("reach_check3", 4, 40);
    line_scan_done = 1'b1; lines_cleared = 3'd4; step(); line_scan_done = 1'b0; #1;
    chk("clear_state", state_out, 5);
    chk("lines_12", lines_total, 12);
    chk("level_1", level, 1);
    cnt = 0;
    for (int g = 0; g < 10 && clear_active; g++) begin cnt++; step(); #1; end
    chk("clear_len", cnt, CC);
    chk("after_clear", state_out, 1);
    piece_grounded = 1'b0;
    tick_gap("gap_level1", 8);

    // Failed spawn, restart, and bookkeeping cleared on the next start.
    piece_grounded = 1'b1;
    wait_state("reach_check4", 4, 40);
    line_scan_done = 1'b1; lines_cleared = 3'd0; spawn_possible = 1'b0;
    step(); line_scan_done = 1'b0;
    chk("spawn_fail_cycle", state_out, 1);
    step();
    chk("over_state", state_out, 7);
    chk("over_level_held", level, 1);
    chk("over_lines_held", lines_total, 12);
    keycode = 8'h28; step(); keycode = '0;
    chk("restart_state", state_out, 0);
    chk("start_level_held", level, 1);
    keycode = 8'h2C; spawn_possible = 1'b1; step(); keycode = '0;
    chk("respawn_state", state_out, 1);
    chk("respawn_level", level, 0);
    chk("respawn_lines", lines_total, 0);

`ifdef TETRIS_PAUSE_EN
    wait_state("reach_lock_p", 3, 20);
    repeat (3) step();
    keycode = 8'h13; step();
    chk("paused", state_out, 6);
    repeat (100) step();
    keycode = '0; step();
    keycode = 8'h13; step();
    lockk = -1;
    for (int k = 1; k < 20 && lockk < 0; k++) begin
      #1;
      if (lock_req) lockk = k;
      step();
    end
    keycode = '0;
    chk("pause_resume", lockk, 5);
    scan_round(0);
    wait_state("reach_lock_p2", 3, 20);
    keycode = 8'h13; step();
    chk("paused_again", state_out, 6);
    keycode = '0; Reset_n = 1'b0; step();
    chk("reset_in_pause", state_out, 0);
    Reset_n = 1'b1;
`endif

    // Randomized play checked cycle by cycle against the model.
    for (int c = 0; c < 20000; c++) begin
      Reset_n = ($urandom_range(0, 1999) != 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 6))
          3: keycode = 8'h2C;
          4: keycode = 8'h28;
          5: keycode = 8'h13;
          6: keycode = 8'($urandom);
          default: keycode = '0;
        endcase
      end
      spawn_possible = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) piece_grounded = ~piece_grounded;
      piece_moved    = ($urandom_range(0, 5) == 0);
      line_scan_done = ($urandom_range(0, 3) == 0);
      lines_cleared  = 3'($urandom_range(0, 4));
      step();
    end
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
